mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the core's dual memory ports: port 0 is the data port from the MEM stage, port 1 is the instruction-fetch port.
- Arbitrates both ports onto one single-port RAM interface with a req/gnt/rvalid handshake.
- Performs byte-lane steering on writes and reads, and returns a one-cycle per-port valid pulse on completion.
- Only one RAM transaction is outstanding at any time.

Parameters:
- BITSIZE, 32, data and address width per port. Only 32 is supported: byte lanes are addr[1:0].

Ports:
- clk  input  1  clock
- resetn_i  input  1  synchronous active-low reset
- core_addr_i  input  2*BITSIZE  per-port address; [BITSIZE-1:0] = port 0, upper half = port 1
- core_data_i  input  2*BITSIZE  per-port write data (port 1 is always 0)
- core_data_o  output  2*BITSIZE  per-port read data
- core_read_i  input  2  per-port read request
- core_write_i  input  2  per-port write request
- core_write_size_i  input  4  per-port size, 2 bits each: 00 byte, 01 half, 10 word, 11 treated as word
- core_valid_o  output  2  per-port completion pulse
- ram_req_o  output  1  RAM request
- ram_gnt_i  input  1  RAM accepts request this cycle
- ram_we_o  output  1  write enable
- ram_be_o  output  BITSIZE/8  byte enables
- ram_addr_o  output  BITSIZE  word-aligned address (addr[1:0] forced to 0)
- ram_wdata_o  output  BITSIZE  lane-steered write data
- ram_rdata_i  input  BITSIZE  read data, valid with ram_rvalid_i
- ram_rvalid_i  input  1  response for the accepted request (reads and writes)

Behaviour:
- Reset is synchronous, active-low. On reset:
  - state returns to IDLE
  - ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o all 0
  - core_valid_o = 0, core_data_o = 0
  - the round-robin pointer favours port 0
- Port p is pending when core_read_i[p] or core_write_i[p] is set. If both are set, the access is a write.
- A requester holds its request and operands stable until it sees core_valid_o[p]. From the cycle after valid, it either deasserts or presents a new request.
- FSM states:
  - IDLE: if no port is pending, stay. If one port is pending, select it. If both are pending, select the port not served last (round-robin). Latch address, data, size and direction; go to REQ.
  - REQ: ram_req_o = 1 with the latched operands. When ram_gnt_i = 1, drop ram_req_o next cycle and go to WAIT. If ram_rvalid_i arrives in the same cycle as ram_gnt_i, go directly to DONE.
  - WAIT: when ram_rvalid_i = 1, capture the read data and go to DONE.
  - DONE: core_valid_o[sel] = 1 for exactly this cycle, update the round-robin pointer, go to IDLE.
- Minimum latency from request to valid is 3 cycles, with gnt in the first REQ cycle and rvalid the next cycle.
- Byte enables, with o = addr[1:0]:
  - byte: be = 1 << o
  - half: be = 0011 << (2*o[1]); addr[0] is ignored
  - word: be = 1111; o is ignored
- Reads drive be = 1111.
- Write data: ram_wdata_o = data << (8*o) for byte, data << (16*o[1]) for half, data for word.
- Read return for port 0: core_data_o[BITSIZE-1:0] = rdata >> (8*o) for byte, rdata >> (16*o[1]) for half, rdata for word. Upper bits come out of the shift unfiltered; sign/zero extension is the MEM stage's job.
- Read return for port 1: always the full word, and size is ignored.
- Writes return core_data_o unchanged.
- core_data_o[p] holds its value until the next read completion on that port.
- A request that appears on the non-selected port while a transaction is in flight waits in pending. No request is ever dropped.
- ram_rvalid_i is ignored in IDLE and REQ (unless gnt is high the same cycle) and in DONE. This covers stray responses after a mid-operation reset.
- Reset mid-transaction abandons it, and no valid is issued for it.

Test Plan:
1. Port 1 reads 0x100, RAM returns 0xDEADBEEF with gnt immediate and rvalid 1 cycle later -> core_valid_o = 2'b10 exactly 3 cycles after the request; upper data half = 0xDEADBEEF.
2. Port 0 byte write 0xA5 to 0x203 -> ram_addr_o = 0x200, ram_be_o = 4'b1000, ram_wdata_o = 0xA5000000, ram_we_o = 1; core_valid_o = 2'b01.
3. Port 0 half read 0x302, RAM word 0x12345678 -> core_data_o[31:0] = 0x00001234.
4. Both ports request continuously from reset -> grants alternate 0,1,0,1. Each valid is a single-cycle pulse on the served port only.
5. gnt held low for 5 cycles -> ram_req_o and operands stay stable. Then gnt and rvalid in the same cycle -> DONE next cycle.
6. resetn_i low while in WAIT, then rvalid pulses after reset releases -> no core_valid_o, core_data_o = 0, next request served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates the data (port 0) and instruction-fetch (port 1) ports onto one
// single-port RAM with round-robin selection, byte-lane steering and one outstanding access.
module mem_arbiter #(
    parameter int unsigned BITSIZE = 32
) (
    input  logic                   clk,
    input  logic                   resetn_i,
    input  logic [2*BITSIZE-1:0]   core_addr_i,
    input  logic [2*BITSIZE-1:0]   core_data_i,
    output logic [2*BITSIZE-1:0]   core_data_o,
    input  logic [1:0]             core_read_i,
    input  logic [1:0]             core_write_i,
    input  logic [3:0]             core_write_size_i,
    output logic [1:0]             core_valid_o,
    output logic                   ram_req_o,
    input  logic                   ram_gnt_i,
    output logic                   ram_we_o,
    output logic [BITSIZE/8-1:0]   ram_be_o,
    output logic [BITSIZE-1:0]     ram_addr_o,
    output logic [BITSIZE-1:0]     ram_wdata_o,
    input  logic [BITSIZE-1:0]     ram_rdata_i,
    input  logic                   ram_rvalid_i
);
    localparam int unsigned BE_W = BITSIZE / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [1:0]         state_q, state_d;
    logic               sel_q, sel_d;
    logic               rr_q, rr_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               we_q, we_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic               req_q, req_d;
    logic [1:0]         valid_q, valid_d;
    logic [BITSIZE-1:0] rdata0_q, rdata0_d;
    logic [BITSIZE-1:0] rdata1_q, rdata1_d;

    logic [1:0]         pending;
    logic               pick;
    logic [BITSIZE-1:0] p_addr, p_data, p_wdata;
    logic [1:0]         p_size, p_off;
    logic               p_we;
    logic [BE_W-1:0]    p_be;
    logic [BITSIZE-1:0] rd_shift;
    logic               complete;

    // Candidate selection and write-side lane steering for the port about to be served.
    always_comb begin
        pending = core_read_i | core_write_i;
        pick    = (pending == 2'b11) ? rr_q : pending[1];
        p_addr  = pick ? core_addr_i[2*BITSIZE-1:BITSIZE] : core_addr_i[BITSIZE-1:0];
        p_data  = pick ? core_data_i[2*BITSIZE-1:BITSIZE] : core_data_i[BITSIZE-1:0];
        p_size  = pick ? core_write_size_i[3:2] : core_write_size_i[1:0];
        p_we    = core_write_i[pick];
        p_off   = p_addr[1:0];
        p_be    = {BE_W{1'b1}};
        p_wdata = p_data;
        if (p_we) begin
            case (p_size)
                SZ_BYTE: begin
                    p_be    = BE_W'(1) << p_off;
                    p_wdata = p_data << {p_off, 3'b000};
                end
                SZ_HALF: begin
                    p_be    = BE_W'(3) << {p_off[1], 1'b0};
                    p_wdata = p_data << {p_off[1], 4'b0000};
                end
                default: begin
                end
            endcase
        end
    end

    // Port 1 always takes the full word; port 0 gets the addressed lane shifted down.
    always_comb begin
        rd_shift = ram_rdata_i;
        if (!sel_q) begin
            case (size_q)
                SZ_BYTE: rd_shift = ram_rdata_i >> {off_q, 3'b000};
                SZ_HALF: rd_shift = ram_rdata_i >> {off_q[1], 4'b0000};
                default: rd_shift = ram_rdata_i;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        off_d    = off_q;
        size_d   = size_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        req_d    = req_q;
        valid_d  = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pending) begin
                    sel_d   = pick;
                    addr_d  = {p_addr[BITSIZE-1:2], 2'b00};
                    off_d   = p_off;
                    size_d  = p_size;
                    we_d    = p_we;
                    be_d    = p_be;
                    wdata_d = p_wdata;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ram_gnt_i) begin
                    req_d = 1'b0;
                    if (ram_rvalid_i) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ram_rvalid_i) begin
                    complete = 1'b1;
                end
            end
            S_DONE: begin
                rr_d    = ~sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The pulse is registered, so it is visible exactly during DONE.
        if (complete) begin
            state_d        = S_DONE;
            valid_d[sel_q] = 1'b1;
            if (!we_q) begin
                if (sel_q) begin
                    rdata1_d = ram_rdata_i;
                end else begin
                    rdata0_d = rd_shift;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
            addr_q   <= '0;
            off_q    <= 2'b00;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            size_q   <= size_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ram_req_o    = req_q;
    assign ram_we_o     = we_q;
    assign ram_be_o     = be_q;
    assign ram_addr_o   = addr_q;
    assign ram_wdata_o  = wdata_q;
    assign core_valid_o = valid_q;
    assign core_data_o  = {rdata1_q, rdata0_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a lane-level memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn_i;
    logic [63:0] core_addr_i, core_data_i, core_data_o;
    logic [1:0]  core_read_i, core_write_i, core_valid_o;
    logic [3:0]  core_write_size_i;
    logic        ram_req_o, ram_gnt_i, ram_we_o, ram_rvalid_i;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    always #5 clk = ~clk;

    mem_arbiter #(.BITSIZE(32)) dut (
        .clk               (clk),
        .resetn_i          (resetn_i),
        .core_addr_i       (core_addr_i),
        .core_data_i       (core_data_i),
        .core_data_o       (core_data_o),
        .core_read_i       (core_read_i),
        .core_write_i      (core_write_i),
        .core_write_size_i (core_write_size_i),
        .core_valid_o      (core_valid_o),
        .ram_req_o         (ram_req_o),
        .ram_gnt_i         (ram_gnt_i),
        .ram_we_o          (ram_we_o),
        .ram_be_o          (ram_be_o),
        .ram_addr_o        (ram_addr_o),
        .ram_wdata_o       (ram_wdata_o),
        .ram_rdata_i       (ram_rdata_i),
        .ram_rvalid_i      (ram_rvalid_i)
    );

    int checks = 0;
    int errors = 0;

    // RAM side: either the automatic responder or manual values from the main sequence.
    bit          auto_en, rand_dly, poke_en;
    int          cfg_g, cfg_r, poke_idx;
    logic [31:0] poke_val;
    logic        m_gnt, m_rv, a_gnt, a_rv;
    logic [31:0] m_rdata, a_rdata;
    logic [31:0] ram_mem [0:511];
    logic [31:0] rec_addr, rec_wdata;
    logic [3:0]  rec_be;
    logic        rec_we;

    assign ram_gnt_i    = auto_en ? a_gnt   : m_gnt;
    assign ram_rvalid_i = auto_en ? a_rv    : m_rv;
    assign ram_rdata_i  = auto_en ? a_rdata : m_rdata;

    typedef struct {
        int          port;
        bit          we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ramw;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h01010101) ^ 32'h5A3C0000;
    endfunction

    function automatic int lane_start(logic [1:0] sz, logic [1:0] o);
        case (sz)
            2'b00:   return int'(o);
            2'b01:   return o[1] ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int lane_count(logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(int s, int n);
        logic [3:0] m = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= s && i < s + n) m[i] = 1'b1;
        return m;
    endfunction

    // Data byte k lands in lane s+k; bytes pushed past lane 3 are lost.
    function automatic logic [31:0] place(logic [31:0] d, int s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) if (i >= s) r[8*i +: 8] = d[8*(i-s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] extract(logic [31:0] w, int s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) if (i + s < 4) r[8*i +: 8] = w[8*(i+s) +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            core_read_i[0] = rd;  core_write_i[0] = wr;  core_write_size_i[1:0] = sz;
            core_addr_i[31:0] = a;  core_data_i[31:0] = d;
        end else begin
            core_read_i[1] = rd;  core_write_i[1] = wr;  core_write_size_i[3:2] = sz;
            core_addr_i[63:32] = a;  core_data_i[63:32] = 32'h0;
        end
    endtask

    task automatic clear_core();
        set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    // Hold one port's request until a valid pulse or the cycle budget runs out.
    task automatic run_txn(input int p, input bit we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d, output int lat);
        set_port(p, !we, we, sz, a, d);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (core_valid_o != 2'b00) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin : ram_model
        bit          counting, r_busy;
        int          cnt, cur_g, rv_cnt, idx;
        logic [31:0] resp;
        for (int i = 0; i < 512; i++) ram_mem[i] = init_word(i);
        a_gnt = 1'b0;  a_rv = 1'b0;  a_rdata = 32'h0;
        counting = 1'b0;  r_busy = 1'b0;  cnt = 0;  cur_g = 0;  rv_cnt = 0;  resp = 32'h0;
        rec_addr = 32'h0;  rec_wdata = 32'h0;  rec_be = 4'h0;  rec_we = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            a_gnt = 1'b0;  a_rv = 1'b0;  a_rdata = 32'h0;
            if (poke_en) ram_mem[poke_idx] = poke_val;
            if (!auto_en || !resetn_i) begin
                counting = 1'b0;
                r_busy   = 1'b0;
            end else if (r_busy) begin
                if (rv_cnt == 0) begin
                    a_rv = 1'b1;  a_rdata = resp;  r_busy = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (ram_req_o) begin
                if (!counting) begin
                    counting = 1'b1;
                    cnt      = 0;
                    cur_g    = rand_dly ? int'($urandom_range(0, 3)) : cfg_g;
                end
                if (cnt >= cur_g) begin
                    a_gnt    = 1'b1;
                    counting = 1'b0;
                    idx      = int'(ram_addr_o[10:2]);
                    rec_addr = ram_addr_o;  rec_be = ram_be_o;
                    rec_we   = ram_we_o;    rec_wdata = ram_wdata_o;
                    if (ram_we_o)
                        for (int b = 0; b < 4; b++)
                            if (ram_be_o[b]) ram_mem[idx][8*b +: 8] = ram_wdata_o[8*b +: 8];
                    resp   = ram_mem[idx];
                    rv_cnt = rand_dly ? int'($urandom_range(0, 3)) : cfg_r;
                    if (rv_cnt == 0) begin
                        a_rv = 1'b1;  a_rdata = resp;
                    end else begin
                        r_busy = 1'b1;
                        rv_cnt--;
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : main
        vec_t        vt[11];
        int          lat, n, s, idx, done_cnt;
        int          order[4];
        logic [1:0]  v, prev;
        logic [3:0]  em;
        logic [31:0] ew;
        logic [31:0] hold[2];
        logic [31:0] mdl_mem [0:511];
        bit          act[2], twe[2];
        logic [1:0]  tsz[2];
        logic [31:0] taddr[2], tdata[2];
        int          age[2];

        auto_en = 1'b1;  rand_dly = 1'b0;  cfg_g = 0;  cfg_r = 1;
        poke_en = 1'b0;  poke_idx = 0;  poke_val = 32'h0;
        m_gnt = 1'b0;  m_rv = 1'b0;  m_rdata = 32'h0;
        resetn_i = 1'b0;
        clear_core();

        // Reset values, sampled while reset is still asserted.
        tick();  tick();
        chk("rst_req",   64'(ram_req_o),   64'(0));
        chk("rst_we",    64'(ram_we_o),    64'(0));
        chk("rst_be",    64'(ram_be_o),    64'(0));
        chk("rst_addr",  64'(ram_addr_o),  64'(0));
        chk("rst_wdata", 64'(ram_wdata_o), 64'(0));
        chk("rst_valid", 64'(core_valid_o), 64'(0));
        chk("rst_data",  core_data_o,      64'(0));
        resetn_i = 1'b1;
        tick();
        hold[0] = 32'h0;  hold[1] = 32'h0;

        // port we sz addr data ramword | be ramaddr wdata rdata
        vt[0]  = '{1, 1'b0, 2'd2, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF, 32'h100, 32'h0,        32'hDEADBEEF};
        vt[1]  = '{0, 1'b1, 2'd0, 32'h203, 32'h000000A5, 32'h0,        4'h8, 32'h200, 32'hA5000000, 32'h0};
        vt[2]  = '{0, 1'b0, 2'd1, 32'h302, 32'h0,        32'h12345678, 4'hF, 32'h300, 32'h0,        32'h00001234};
        vt[3]  = '{0, 1'b1, 2'd1, 32'h106, 32'h0000BEEF, 32'h0,        4'hC, 32'h104, 32'hBEEF0000, 32'h0};
        vt[4]  = '{0, 1'b0, 2'd0, 32'h0C1, 32'h0,        32'hAABBCCDD, 4'hF, 32'h0C0, 32'h0,        32'h00AABBCC};
        vt[5]  = '{0, 1'b1, 2'd3, 32'h0F3, 32'h01020304, 32'h0,        4'hF, 32'h0F0, 32'h01020304, 32'h0};
        vt[6]  = '{1, 1'b0, 2'd0, 32'h10A, 32'h0,        32'h55667788, 4'hF, 32'h108, 32'h0,        32'h55667788};
        vt[7]  = '{0, 1'b1, 2'd0, 32'h041, 32'h123456FF, 32'h0,        4'h2, 32'h040, 32'h3456FF00, 32'h0};
        vt[8]  = '{0, 1'b1, 2'd1, 32'h2A1, 32'h0000CAFE, 32'h0,        4'h3, 32'h2A0, 32'h0000CAFE, 32'h0};
        vt[9]  = '{0, 1'b0, 2'd2, 32'h2A7, 32'h0,        32'h87654321, 4'hF, 32'h2A4, 32'h0,        32'h87654321};
        vt[10] = '{0, 1'b0, 2'd0, 32'h2AB, 32'h0,        32'h87654321, 4'hF, 32'h2A8, 32'h0,        32'h00000087};

        for (int i = 0; i < 11; i++) begin
            if (!vt[i].we) begin
                poke_idx = int'(vt[i].raddr[10:2]);  poke_val = vt[i].ramw;  poke_en = 1'b1;
            end
            run_txn(vt[i].port, vt[i].we, vt[i].sz, vt[i].addr, vt[i].data, lat);
            poke_en = 1'b0;
            chk("vec_latency", 64'(lat), 64'(3));
            chk("vec_valid", 64'(core_valid_o), (vt[i].port == 1) ? 64'(2'b10) : 64'(2'b01));
            chk("vec_ram_addr", 64'(rec_addr), 64'(vt[i].raddr));
            chk("vec_ram_be", 64'(rec_be), 64'(vt[i].be));
            chk("vec_ram_we", 64'(rec_we), 64'(vt[i].we));
            if (vt[i].we) chk("vec_ram_wdata", 64'(rec_wdata), 64'(vt[i].wd));
            else hold[vt[i].port] = vt[i].rd;
            chk("vec_core_data", core_data_o, {hold[1], hold[0]});
            clear_core();
            tick();
            chk("vec_single_pulse", 64'(core_valid_o), 64'(0));
        end

        // Both ports requesting continuously from reset alternate 0,1,0,1.
        resetn_i = 1'b0;  tick();  resetn_i = 1'b1;
        set_port(0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
        set_port(1, 1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
        n = 0;  prev = 2'b00;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            v = core_valid_o;
            if (v != 2'b00) begin
                chk("rr_onehot", 64'(v == 2'b01 || v == 2'b10), 64'(1));
                chk("rr_pulse_gap", 64'(prev), 64'(0));
                order[n] = v[1] ? 1 : 0;
                n++;
            end
            prev = v;
        end
        chk("rr_count", 64'(n), 64'(4));
        for (int i = 0; i < n; i++) chk("rr_order", 64'(order[i]), 64'(i % 2));
        chk("rr_data", core_data_o, {init_word(1), init_word(0)});
        hold[0] = init_word(0);  hold[1] = init_word(1);
        clear_core();
        tick();  tick();

        // Grant withheld for five cycles, then gnt and rvalid together.
        auto_en = 1'b0;
        set_port(0, 1'b0, 1'b1, 2'b10, 32'h44, 32'h11223344);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_operands", {26'h0, ram_req_o, ram_we_o, ram_be_o, ram_addr_o},
                {26'h0, 1'b1, 1'b1, 4'hF, 32'h44});
            chk("stall_wdata", 64'(ram_wdata_o), 64'(32'h11223344));
        end
        m_gnt = 1'b1;  m_rv = 1'b1;
        tick();
        chk("stall_done_valid", 64'(core_valid_o), 64'(2'b01));
        m_gnt = 1'b0;  m_rv = 1'b0;
        clear_core();
        tick();
        chk("stall_after", 64'({ram_req_o, core_valid_o}), 64'(0));

        // Reset while waiting for rvalid; a stray rvalid afterwards must be ignored.
        set_port(0, 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        m_gnt = 1'b1;
        tick();
        chk("midrst_req", 64'(ram_req_o), 64'(1));
        tick();
        m_gnt = 1'b0;
        chk("midrst_wait", 64'(ram_req_o), 64'(0));
        resetn_i = 1'b0;
        clear_core();
        tick();
        resetn_i = 1'b1;
        m_rv = 1'b1;  m_rdata = 32'hCAFEF00D;
        tick();
        m_rv = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("midrst_quiet", {core_data_o[61:0], core_valid_o}, 64'(0));
            chk("midrst_no_req", 64'(ram_req_o), 64'(0));
            tick();
        end
        hold[0] = 32'h0;  hold[1] = 32'h0;
        auto_en = 1'b1;
        poke_idx = 8;  poke_val = 32'h13572468;  poke_en = 1'b1;
        run_txn(1, 1'b0, 2'b10, 32'h20, 32'h0, lat);
        poke_en = 1'b0;
        chk("midrst_next_latency", 64'(lat), 64'(3));
        chk("midrst_next_data", core_data_o, {32'h13572468, 32'h0});
        hold[1] = 32'h13572468;
        clear_core();
        tick();

        // Randomized traffic on both ports with random RAM delays.
        resetn_i = 1'b0;  tick();  resetn_i = 1'b1;
        hold[0] = 32'h0;  hold[1] = 32'h0;
        for (int i = 0; i < 512; i++) mdl_mem[i] = init_word(i);
        rand_dly = 1'b1;
        done_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0;  twe[p] = 1'b0;  tsz[p] = 2'b00;
            taddr[p] = 32'h0;  tdata[p] = 32'h0;  age[p] = 0;
        end
        for (int cyc = 0; cyc < 1700; cyc++) begin
            tick();
            v = core_valid_o;
            if (v != 2'b00) chk("rnd_onehot", 64'(v != 2'b11), 64'(1));
            for (int p = 0; p < 2; p++) begin
                if (v[p]) begin
                    chk("rnd_expected_valid", 64'(act[p]), 64'(1));
                    if (act[p]) begin
                        s   = lane_start(tsz[p], taddr[p][1:0]);
                        em  = twe[p] ? lane_mask(s, lane_count(tsz[p])) : 4'hF;
                        idx = int'(taddr[p][10:2]);
                        chk("rnd_ram_addr", 64'(rec_addr), 64'({taddr[p][31:2], 2'b00}));
                        chk("rnd_ram_be", 64'(rec_be), 64'(em));
                        chk("rnd_ram_we", 64'(rec_we), 64'(twe[p]));
                        if (twe[p]) begin
                            ew = place(tdata[p], s);
                            chk("rnd_ram_wdata", 64'(rec_wdata), 64'(ew));
                            for (int b = 0; b < 4; b++)
                                if (em[b]) mdl_mem[idx][8*b +: 8] = ew[8*b +: 8];
                        end else begin
                            hold[p] = (p == 0) ? extract(mdl_mem[idx], s) : mdl_mem[idx];
                        end
                        chk("rnd_core_data", core_data_o, {hold[1], hold[0]});
                        act[p] = 1'b0;
                        set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                        done_cnt++;
                    end
                end else if (act[p]) begin
                    age[p]++;
                    if (age[p] > 100) begin
                        chk("rnd_timeout", 64'(age[p]), 64'(100));
                        act[p] = 1'b0;
                        set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                    end
                end else if (cyc < 1500 && $urandom_range(0, 1) == 1) begin
                    twe[p]   = (p == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    tsz[p]   = 2'($urandom_range(0, 3));
                    taddr[p] = 32'h400 + 32'($urandom_range(0, 1023));
                    tdata[p] = (p == 0) ? $urandom : 32'h0;
                    act[p]   = 1'b1;
                    age[p]   = 0;
                    set_port(p, twe[p] ? 1'($urandom_range(0, 1)) : 1'b1, twe[p],
                             tsz[p], taddr[p], tdata[p]);
                end
            end
        end
        chk("rnd_drained", 64'({act[1], act[0]}), 64'(0));
        chk("rnd_progress", 64'(done_cnt > 100), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
